// File: rtl/power_off_timer.sv
// Power-off timer: prescaled one-shot/watchdog countdown that latches a board
// power-kill request on expiry, with a pre-expiry warning and status readback.
`timescale 1ns/1ps

module power_off_timer #(
    parameter int unsigned CLK_DIV    = 5000000,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WARN_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [23:0]      in_data,
    input  logic             in_wr,
    output logic             pwr_off,
    output logic             warn,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    localparam int unsigned PW = $clog2(CLK_DIV);

    localparam logic [1:0] CMD_LOAD   = 2'b00;
    localparam logic [1:0] CMD_ARM    = 2'b01;
    localparam logic [1:0] CMD_KICK   = 2'b10;
    localparam logic [1:0] CMD_CANCEL = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ONESHOT  = 2'b01,
        WATCHDOG = 2'b10,
        OFF      = 2'b11
    } state_t;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [21:0] value;
    } wr_word_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] reload, reload_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic             busy_nxt, warn_nxt;
    logic             stb;
    wr_word_t         wr_word;
    logic [CNT_W-1:0] wr_val;
    logic             unused_value_bits;

    assign wr_word = wr_word_t'(in_data);
    assign wr_val  = wr_word.value[CNT_W-1:0];
    // Value bits above the counter width carry no meaning for this block.
    assign unused_value_bits = ^(wr_word.value >> CNT_W);

    assign stb = busy && (presc == PW'(CLK_DIV - 1));

    // Next-state: tick countdown first, then an accepted write overrides it.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = remaining;
        reload_nxt = reload;
        presc_nxt  = '0;

        if (busy) begin
            presc_nxt = stb ? '0 : presc + PW'(1);
        end

        if (stb) begin
            if (remaining == CNT_W'(1)) begin
                cnt_nxt   = '0;
                state_nxt = OFF;
            end else begin
                cnt_nxt = remaining - CNT_W'(1);
            end
        end

        if (in_wr && (state != OFF)) begin
            unique case (wr_word.cmd)
                CMD_LOAD: begin
                    cnt_nxt   = wr_val;
                    presc_nxt = '0;
                    state_nxt = (wr_val != '0) ? ONESHOT : IDLE;
                end
                CMD_ARM: begin
                    reload_nxt = wr_val;
                    cnt_nxt    = wr_val;
                    presc_nxt  = '0;
                    state_nxt  = (wr_val != '0) ? WATCHDOG : IDLE;
                end
                CMD_KICK: begin
                    if (state == WATCHDOG) begin
                        cnt_nxt   = reload;
                        presc_nxt = '0;
                        state_nxt = WATCHDOG;
                    end
                end
                CMD_CANCEL: begin
                    cnt_nxt   = '0;
                    presc_nxt = '0;
                    state_nxt = IDLE;
                end
                default: ;
            endcase
        end

        busy_nxt = (state_nxt == ONESHOT) || (state_nxt == WATCHDOG);
        if (!busy_nxt) begin
            presc_nxt = '0;
        end
        warn_nxt = busy_nxt && (cnt_nxt != '0) && (cnt_nxt <= CNT_W'(WARN_TICKS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            reload    <= '0;
            presc     <= '0;
            busy      <= 1'b0;
            warn      <= 1'b0;
            pwr_off   <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= cnt_nxt;
            reload    <= reload_nxt;
            presc     <= presc_nxt;
            busy      <= busy_nxt;
            warn      <= warn_nxt;
            pwr_off   <= (state_nxt == OFF);
        end
    end

endmodule

// File: tb/tb_power_off_timer.sv
// Scoreboard bench for power_off_timer: time-based reference model pushes the
// expected outputs for every clock edge; a monitor pops and compares them.
`timescale 1ns/1ps

module tb_power_off_timer;

    localparam int unsigned D  = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned WT = 2;

    logic          clk;
    logic          rst_n;
    logic [23:0]   in_data;
    logic          in_wr;
    logic          pwr_off;
    logic          warn;
    logic          busy;
    logic [CW-1:0] remaining;

    power_off_timer #(.CLK_DIV(D), .CNT_W(CW), .WARN_TICKS(WT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_wr     (in_wr),
        .pwr_off   (pwr_off),
        .warn      (warn),
        .busy      (busy),
        .remaining (remaining)
    );

    typedef struct packed {
        logic          p;
        logic          w;
        logic          b;
        logic [CW-1:0] r;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: a running timer is (start edge, start value); the count is
    // derived from elapsed edges, expiry is the edge start + value*D.
    int m_st;   // 0 idle, 1 oneshot, 2 watchdog, 3 off
    int m_t0;
    int m_n0;
    int m_rel;
    int m_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_x = q.pop_front();
            check("pwr_off",   int'(pwr_off),   int'(mon_x.p));
            check("warn",      int'(warn),      int'(mon_x.w));
            check("busy",      int'(busy),      int'(mon_x.b));
            check("remaining", int'(remaining), int'(mon_x.r));
        end
    end

    task automatic model_reset();
        m_st = 0; m_t0 = 0; m_n0 = 0; m_rel = 0; m_e = 0;
    endtask

    task automatic model_edge(input logic wr, input logic [23:0] d);
        int   v;
        int   cnt;
        bit   acc;
        bit   bsy;
        exp_t x;
        m_e++;
        acc = 0;
        v   = int'(d[CW-1:0]);
        if (wr && m_st != 3) begin
            case (d[23:22])
                2'b00: begin m_n0 = v; m_t0 = m_e; m_st = (v != 0) ? 1 : 0; acc = 1; end
                2'b01: begin m_rel = v; m_n0 = v; m_t0 = m_e; m_st = (v != 0) ? 2 : 0; acc = 1; end
                2'b10: if (m_st == 2) begin m_n0 = m_rel; m_t0 = m_e; acc = 1; end
                default: begin m_st = 0; acc = 1; end
            endcase
        end
        if (!acc && (m_st == 1 || m_st == 2) && (m_e - m_t0) == m_n0 * int'(D)) m_st = 3;
        bsy = (m_st == 1 || m_st == 2);
        cnt = bsy ? m_n0 - (m_e - m_t0) / int'(D) : 0;
        x.p = (m_st == 3);
        x.b = bsy;
        x.w = bsy && cnt != 0 && cnt <= int'(WT);
        x.r = CW'(cnt);
        q.push_back(x);
    endtask

    function automatic logic [23:0] cmd(input int c, input int v);
        logic [13:0] junk;
        junk = 14'($urandom);
        return {2'(c), junk, 8'(v)};
    endfunction

    task automatic step(input logic wr, input logic [23:0] d);
        in_wr   = wr;
        in_data = d;
        @(posedge clk);
        model_edge(wr, d);
        #1;
        in_wr   = 1'b0;
        in_data = 24'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0);
    endtask

    // Asserts reset mid-cycle and checks outputs clear without a clock edge.
    task automatic reset_dut();
        #2;
        q.delete();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_pwr_off",   int'(pwr_off),   0);
        check("rst_warn",      int'(warn),      0);
        check("rst_busy",      int'(busy),      0);
        check("rst_remaining", int'(remaining), 0);
        repeat (2) begin
            @(posedge clk);
            q.push_back('0);
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b1;
        in_wr   = 1'b0;
        in_data = 24'h0;
        model_reset();

        // 1: LOAD 3 oneshot expiry and sticky OFF
        reset_dut();
        step(1'b1, cmd(0, 3));
        idle(4);
        check("s1_rem_after_tick1", int'(remaining), 2);
        check("s1_warn_after_tick1", int'(warn), 1);
        idle(8);
        check("s1_pwr_off", int'(pwr_off), 1);
        idle(100);
        check("s1_pwr_off_hold", int'(pwr_off), 1);

        // 2: watchdog kept alive, then expiry 20 cycles after last KICK
        reset_dut();
        step(1'b1, cmd(1, 5));
        for (int k = 0; k < 10; k++) begin
            idle(11);
            step(1'b1, cmd(2, 0));
        end
        idle(19);
        check("s2_not_yet", int'(pwr_off), 0);
        idle(1);
        check("s2_expired", int'(pwr_off), 1);

        // 3: CANCEL, KICK in IDLE, LOAD 0
        reset_dut();
        step(1'b1, cmd(0, 3));
        idle(5);
        step(1'b1, cmd(3, 0));
        idle(100);
        check("s3_busy", int'(busy), 0);
        step(1'b1, cmd(2, 0));
        idle(3);
        step(1'b1, cmd(0, 0));
        idle(8);

        // 4: reload on the stb edge, then KICK on the expiry edge
        reset_dut();
        step(1'b1, cmd(0, 10));
        idle(7);
        step(1'b1, cmd(0, 7));
        check("s4_reload_val", int'(remaining), 7);
        idle(4);
        check("s4_next_dec", int'(remaining), 6);
        step(1'b1, cmd(1, 2));
        idle(7);
        step(1'b1, cmd(2, 0));
        check("s4_kick_saves", int'(pwr_off), 0);
        idle(8);

        // 5: writes in OFF ignored
        check("s5_off", int'(pwr_off), 1);
        step(1'b1, cmd(0, 50));
        step(1'b1, cmd(3, 0));
        idle(10);
        check("s5_still_off", int'(pwr_off), 1);

        // 6: async reset mid-countdown
        reset_dut();
        step(1'b1, cmd(0, 9));
        idle(5);
        reset_dut();
        idle(20);

        // Random traffic against the model
        for (int r = 0; r < 8; r++) begin
            reset_dut();
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 7) == 0)
                    step(1'b1, cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 7))));
                else
                    step(1'b0, 24'h0);
            end
        end

        @(negedge clk);
        #1;
        check("sb_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
